// File: rtl/bldc_emu_pkg.sv
// Shared constants for the BLDC hall/encoder emulator: hall table, fault
// encodings and the quadrature Gray sequence.
package bldc_emu_pkg;

  localparam int unsigned SECTOR_COUNT = 6;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'b00,
    FAULT_HALL_LOW   = 2'b01,
    FAULT_HALL_HIGH  = 2'b10,
    FAULT_ENC_FREEZE = 2'b11
  } fault_mode_e;

  localparam logic [2:0] HALL_RESET = 3'b101;

  localparam logic [1:0] QUAD_SEQ0 = 2'b00;
  localparam logic [1:0] QUAD_SEQ1 = 2'b01;
  localparam logic [1:0] QUAD_SEQ2 = 2'b11;
  localparam logic [1:0] QUAD_SEQ3 = 2'b10;

  function automatic logic [2:0] hall_code(input logic [2:0] sec);
    logic [2:0] code;
    case (sec)
      3'd0:    code = 3'b101;
      3'd1:    code = 3'b100;
      3'd2:    code = 3'b110;
      3'd3:    code = 3'b010;
      3'd4:    code = 3'b011;
      3'd5:    code = 3'b001;
      default: code = HALL_RESET;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] quad_code(input logic [1:0] idx);
    logic [1:0] code;
    case (idx)
      2'd0:    code = QUAD_SEQ0;
      2'd1:    code = QUAD_SEQ1;
      2'd2:    code = QUAD_SEQ2;
      2'd3:    code = QUAD_SEQ3;
      default: code = QUAD_SEQ0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bldc_step_timer.sv
// Prescaler that emits one step event every `period` enabled clocks; a
// clear strobe restarts the count and suppresses the coincident event.
module bldc_step_timer #(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    clear,
  output logic                    step
);

  logic [PERIOD_WIDTH-1:0] prescaler_q;
  logic [PERIOD_WIDTH-1:0] prescaler_d;
  logic                    active_s;

  // A shortened period is compared against the running count, so it can fire at once.
  assign active_s = en & (period != {PERIOD_WIDTH{1'b0}});
  assign step     = active_s & ~reset & ~clear & (prescaler_q >= (period - PERIOD_WIDTH'(1)));

  always_comb begin
    prescaler_d = prescaler_q;
    if (clear) begin
      prescaler_d = {PERIOD_WIDTH{1'b0}};
    end else if (step) begin
      prescaler_d = {PERIOD_WIDTH{1'b0}};
    end else if (active_s) begin
      prescaler_d = prescaler_q + PERIOD_WIDTH'(1);
    end else begin
      prescaler_d = prescaler_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q <= {PERIOD_WIDTH{1'b0}};
    end else begin
      prescaler_q <= prescaler_d;
    end
  end

endmodule

// File: rtl/bldc_hall_encoder_emulator.sv
// Motor-side emulator: turns a step period and direction into phased hall
// codes and quadrature edges, with output-only fault injection.
module bldc_hall_encoder_emulator
  import bldc_emu_pkg::*;
#(
  parameter int PERIOD_WIDTH         = 16,
  parameter int ENC_TICKS_PER_SECTOR = 12,
  parameter int ENC_COUNT_WIDTH      = 15
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic [PERIOD_WIDTH-1:0]           period,
  input  logic                              direction,
  input  logic [1:0]                        fault_mode,
  input  logic                              load_sector,
  input  logic [2:0]                        sector_init,
  output logic [2:0]                        hall,
  output logic [1:0]                        enc,
  output logic [2:0]                        sector,
  output logic signed [ENC_COUNT_WIDTH-1:0] enc_edge_count,
  output logic                              step
);

  localparam int SUB_W = (ENC_TICKS_PER_SECTOR > 1) ? $clog2(ENC_TICKS_PER_SECTOR) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(ENC_TICKS_PER_SECTOR - 1);
  localparam logic [2:0]       SECTOR_MAX = 3'(SECTOR_COUNT - 1);

  logic                              event_s;
  logic [SUB_W-1:0]                  sub_q, sub_d;
  logic [2:0]                        sector_q, sector_d;
  logic [1:0]                        quad_idx_q, quad_idx_d;
  logic signed [ENC_COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]                        hall_q, hall_d;
  logic [1:0]                        enc_q, enc_d;

  bldc_step_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .period (period),
    .clear  (load_sector),
    .step   (event_s)
  );

  assign step           = event_s;
  assign hall           = hall_q;
  assign enc            = enc_q;
  assign sector         = sector_q;
  assign enc_edge_count = cnt_q;

  // Next internal position, then fault-muxed outputs built from that next state.
  always_comb begin
    sub_d      = sub_q;
    sector_d   = sector_q;
    quad_idx_d = quad_idx_q;
    cnt_d      = cnt_q;
    if (load_sector) begin
      sector_d = (sector_init > SECTOR_MAX) ? 3'd0 : sector_init;
      sub_d    = {SUB_W{1'b0}};
    end else if (event_s && !direction) begin
      quad_idx_d = quad_idx_q + 2'd1;
      cnt_d      = cnt_q + ENC_COUNT_WIDTH'(1);
      if (sub_q == SUB_LAST) begin
        sub_d    = {SUB_W{1'b0}};
        sector_d = (sector_q == SECTOR_MAX) ? 3'd0 : sector_q + 3'd1;
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end else if (event_s && direction) begin
      quad_idx_d = quad_idx_q - 2'd1;
      cnt_d      = cnt_q - ENC_COUNT_WIDTH'(1);
      if (sub_q == {SUB_W{1'b0}}) begin
        sub_d    = SUB_LAST;
        sector_d = (sector_q == 3'd0) ? SECTOR_MAX : sector_q - 3'd1;
      end else begin
        sub_d = sub_q - SUB_W'(1);
      end
    end else begin
      sub_d = sub_q;
    end

    case (fault_mode)
      FAULT_HALL_LOW:  hall_d = 3'b000;
      FAULT_HALL_HIGH: hall_d = 3'b111;
      default:         hall_d = hall_code(sector_d);
    endcase

    if (fault_mode == FAULT_ENC_FREEZE) begin
      enc_d = enc_q;
    end else begin
      enc_d = quad_code(quad_idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q      <= {SUB_W{1'b0}};
      sector_q   <= 3'd0;
      quad_idx_q <= 2'd0;
      cnt_q      <= {ENC_COUNT_WIDTH{1'b0}};
      hall_q     <= HALL_RESET;
      enc_q      <= QUAD_SEQ0;
    end else begin
      sub_q      <= sub_d;
      sector_q   <= sector_d;
      quad_idx_q <= quad_idx_d;
      cnt_q      <= cnt_d;
      hall_q     <= hall_d;
      enc_q      <= enc_d;
    end
  end

endmodule
